// File: rtl/mnist_image_sequencer.sv
// mnist_image_sequencer: streams ROM images into the MNIST core and checks its class against image_num mod 10
module mnist_image_sequencer #(
    parameter int IMAGE_COUNT = 480,
    parameter int BYTES_PER_IMAGE = 32,
    parameter int RESULT_LATENCY = 2,
    parameter bit STOP_ON_FAIL = 1'b1,
    localparam int AW = $clog2(IMAGE_COUNT * BYTES_PER_IMAGE),
    localparam int IW = $clog2(IMAGE_COUNT) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          step_en,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    output logic [7:0]    core_data,
    output logic          frame_sync,
    input  logic [3:0]    core_index,
    input  logic [7:0]    core_value,
    output logic          result_valid,
    output logic [3:0]    result_index,
    output logic [7:0]    result_value,
    output logic [3:0]    expected_label,
    output logic [IW-1:0] image_num,
    output logic [IW-1:0] fail_count,
    output logic          failure,
    output logic          success,
    output logic          busy
);
    localparam int CW = $clog2(BYTES_PER_IMAGE + RESULT_LATENCY + 1);
    localparam logic [CW-1:0] FETCH_LAST = CW'(BYTES_PER_IMAGE);
    localparam logic [CW-1:0] ADDR_LAST = CW'(BYTES_PER_IMAGE - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(RESULT_LATENCY - 1);
    localparam logic [IW-1:0] LAST_IMG = IW'(IMAGE_COUNT - 1);
    localparam logic [AW-1:0] BPI_A = AW'(BYTES_PER_IMAGE);

    typedef enum logic [2:0] {IDLE, WAIT_STEP, FETCH, DRAIN, CHECK, DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]    core_data_q, core_data_d;
    logic          frame_sync_q, frame_sync_d;
    logic          result_valid_q, result_valid_d;
    logic [3:0]    result_index_q, result_index_d;
    logic [7:0]    result_value_q, result_value_d;
    logic [3:0]    label_q, label_d;
    logic [IW-1:0] image_num_q, image_num_d;
    logic [IW-1:0] fail_count_q, fail_count_d;
    logic          failure_q, failure_d;
    logic          success_q, success_d;
    logic          busy_q, busy_d;
    logic          adv_q, adv_d;
    logic [IW-1:0] img_cur, fc_inc, fc_next;
    logic [3:0]    lbl_cur;
    logic          mismatch;

    // Image/label advance one cycle after CHECK so they stay aligned with result_valid
    assign img_cur  = adv_q ? image_num_q + IW'(1) : image_num_q;
    assign lbl_cur  = adv_q ? (label_q == 4'd9 ? 4'd0 : label_q + 4'd1) : label_q;
    assign mismatch = core_index != label_q;
    assign fc_inc   = &fail_count_q ? fail_count_q : fail_count_q + IW'(1);
    assign fc_next  = mismatch ? fc_inc : fail_count_q;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        rom_addr_d     = rom_addr_q;
        frame_sync_d   = 1'b0;
        result_valid_d = 1'b0;
        result_index_d = result_index_q;
        result_value_d = result_value_q;
        label_d        = lbl_cur;
        image_num_d    = img_cur;
        fail_count_d   = fail_count_q;
        failure_d      = failure_q;
        success_d      = success_q;
        adv_d          = 1'b0;
        core_data_d    = (state_q == FETCH && cnt_q != '0) ? rom_data :
                         (state_q == DRAIN ? core_data_q : 8'd0);
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = WAIT_STEP;
                    image_num_d  = '0;
                    label_d      = '0;
                    fail_count_d = '0;
                    failure_d    = 1'b0;
                    success_d    = 1'b0;
                end
            end
            WAIT_STEP: begin
                if (step_en) begin
                    state_d    = FETCH;
                    cnt_d      = '0;
                    rom_addr_d = AW'(img_cur) * BPI_A;
                end
            end
            FETCH: begin
                cnt_d        = cnt_q + CW'(1);
                frame_sync_d = cnt_q == CW'(1);
                if (cnt_q < ADDR_LAST) rom_addr_d = rom_addr_q + AW'(1);
                if (cnt_q == FETCH_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == DRAIN_LAST) begin
                    state_d = CHECK;
                    cnt_d   = '0;
                end
            end
            CHECK: begin
                result_valid_d = 1'b1;
                result_index_d = core_index;
                result_value_d = core_value;
                fail_count_d   = fc_next;
                failure_d      = failure_q | mismatch;
                if (STOP_ON_FAIL && mismatch) begin
                    state_d = DONE;
                end else if (image_num_q == LAST_IMG) begin
                    state_d   = DONE;
                    success_d = fc_next == '0;
                end else begin
                    state_d = WAIT_STEP;
                    adv_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d != IDLE && state_d != DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            rom_addr_q     <= '0;
            core_data_q    <= '0;
            frame_sync_q   <= 1'b0;
            result_valid_q <= 1'b0;
            result_index_q <= '0;
            result_value_q <= '0;
            label_q        <= '0;
            image_num_q    <= '0;
            fail_count_q   <= '0;
            failure_q      <= 1'b0;
            success_q      <= 1'b0;
            busy_q         <= 1'b0;
            adv_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rom_addr_q     <= rom_addr_d;
            core_data_q    <= core_data_d;
            frame_sync_q   <= frame_sync_d;
            result_valid_q <= result_valid_d;
            result_index_q <= result_index_d;
            result_value_q <= result_value_d;
            label_q        <= label_d;
            image_num_q    <= image_num_d;
            fail_count_q   <= fail_count_d;
            failure_q      <= failure_d;
            success_q      <= success_d;
            busy_q         <= busy_d;
            adv_q          <= adv_d;
        end
    end

    assign rom_addr       = rom_addr_q;
    assign core_data      = core_data_q;
    assign frame_sync     = frame_sync_q;
    assign result_valid   = result_valid_q;
    assign result_index   = result_index_q;
    assign result_value   = result_value_q;
    assign expected_label = label_q;
    assign image_num      = image_num_q;
    assign fail_count     = fail_count_q;
    assign failure        = failure_q;
    assign success        = success_q;
    assign busy           = busy_q;
endmodule

// File: tb/tb_mnist_image_sequencer.sv
// tb_mnist_image_sequencer: directed bench; dut_a stops on first fail, dut_b counts fails and continues
module tb_mnist_image_sequencer;
    localparam int AW = 14;
    localparam int IW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic start_a = 1'b0, step_a = 1'b0, start_b = 1'b0, step_b = 1'b0;
    logic [AW-1:0] rom_addr_a, rom_addr_b;
    logic [7:0] rom_data_a = 8'd0, rom_data_b = 8'd0;
    logic [7:0] core_data_a, core_data_b, core_value_a, core_value_b;
    logic [7:0] result_value_a, result_value_b;
    logic [3:0] core_index_a, core_index_b, result_index_a, result_index_b;
    logic [3:0] expected_label_a, expected_label_b;
    logic [IW-1:0] image_num_a, image_num_b, fail_count_a, fail_count_b;
    logic frame_sync_a, frame_sync_b, result_valid_a, result_valid_b;
    logic failure_a, failure_b, success_a, success_b, busy_a, busy_b;

    int cur_a = 0, cur_b = 0, bad_a = -1, bad_b1 = -1, bad_b2 = -1;
    int n_checks = 0, n_err = 0, pulses_a = 0, pulses_b = 0;
    bit sel = 1'b0;

    function automatic logic [3:0] cls(int img, int b1, int b2);
        return (img == b1 || img == b2) ? 4'd3 : 4'(img % 10);
    endfunction

    function automatic logic [7:0] exp_byte(int img, int n);
        if (n < 2) return 8'd0;
        if (n <= 33) return 8'(img * 32 + n - 2);
        if (n <= 35) return 8'(img * 32 + 31);
        return 8'd0;
    endfunction

    // ROM model: byte = addr[7:0], one-cycle read; core model: class = image mod 10 unless marked bad
    always @(posedge clk) begin
        rom_data_a <= rom_addr_a[7:0];
        rom_data_b <= rom_addr_b[7:0];
        if (result_valid_a) pulses_a <= pulses_a + 1;
        if (result_valid_b) pulses_b <= pulses_b + 1;
    end
    assign core_index_a = cls(cur_a, bad_a, -1);
    assign core_index_b = cls(cur_b, bad_b1, bad_b2);
    assign core_value_a = 8'(cur_a * 7 + 1);
    assign core_value_b = 8'(cur_b * 7 + 1);

    mnist_image_sequencer #(.STOP_ON_FAIL(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .step_en(step_a),
        .rom_addr(rom_addr_a), .rom_data(rom_data_a), .core_data(core_data_a),
        .frame_sync(frame_sync_a), .core_index(core_index_a), .core_value(core_value_a),
        .result_valid(result_valid_a), .result_index(result_index_a),
        .result_value(result_value_a), .expected_label(expected_label_a),
        .image_num(image_num_a), .fail_count(fail_count_a), .failure(failure_a),
        .success(success_a), .busy(busy_a)
    );

    mnist_image_sequencer #(.STOP_ON_FAIL(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .step_en(step_b),
        .rom_addr(rom_addr_b), .rom_data(rom_data_b), .core_data(core_data_b),
        .frame_sync(frame_sync_b), .core_index(core_index_b), .core_value(core_value_b),
        .result_valid(result_valid_b), .result_index(result_index_b),
        .result_value(result_value_b), .expected_label(expected_label_b),
        .image_num(image_num_b), .fail_count(fail_count_b), .failure(failure_b),
        .success(success_b), .busy(busy_b)
    );

    logic obs_rv, obs_fs;
    logic [7:0] obs_cd, obs_val;
    logic [3:0] obs_idx, obs_lbl;
    logic [IW-1:0] obs_img;
    logic [AW-1:0] obs_addr;
    assign obs_rv   = sel ? result_valid_b : result_valid_a;
    assign obs_fs   = sel ? frame_sync_b : frame_sync_a;
    assign obs_cd   = sel ? core_data_b : core_data_a;
    assign obs_val  = sel ? result_value_b : result_value_a;
    assign obs_idx  = sel ? result_index_b : result_index_a;
    assign obs_lbl  = sel ? expected_label_b : expected_label_a;
    assign obs_img  = sel ? image_num_b : image_num_a;
    assign obs_addr = sel ? rom_addr_b : rom_addr_a;

    typedef struct packed {
        logic [3:0]    idx;
        logic [7:0]    val;
        logic [3:0]    lbl;
        logic [IW-1:0] img;
    } exp_t;
    exp_t sb[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_step(logic v);
        if (sel) step_b = v; else step_a = v;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        if (sel) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic run_image(int img, bit trace, bit spam);
        exp_t e, got;
        int n;
        if (sel) cur_b = img; else cur_a = img;
        e.idx = sel ? cls(img, bad_b1, bad_b2) : cls(img, bad_a, -1);
        e.val = 8'(img * 7 + 1);
        e.lbl = 4'(img % 10);
        e.img = IW'(img);
        sb.push_back(e);
        @(negedge clk);
        drive_step(1'b1);
        @(negedge clk);
        drive_step(1'b0);
        n = 0;
        while (!obs_rv && n < 60) begin
            if (trace) begin
                if (n == 0) chk("rom_addr_first", obs_addr, img * 32);
                chk("core_data", obs_cd, exp_byte(img, n));
                chk("frame_sync", obs_fs, n == 2);
            end
            @(negedge clk);
            drive_step(spam && (n == 4 || n == 33));
            n++;
        end
        drive_step(1'b0);
        if (trace) chk("latency", n, 36);
        got = sb.pop_front();
        if (n >= 60) begin
            chk("rv_timeout", obs_rv, 1);
        end else begin
            chk("result_index", obs_idx, got.idx);
            chk("result_value", obs_val, got.val);
            chk("expected_label", obs_lbl, got.lbl);
            chk("image_num", obs_img, got.img);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_core_data", core_data_a, 0);
        chk("rst_frame_sync", frame_sync_a, 0);
        chk("rst_rom_addr", rom_addr_a, 0);
        chk("rst_rv", result_valid_a, 0);
        chk("rst_index", result_index_a, 0);
        chk("rst_image_num", image_num_a, 0);
        chk("rst_fail_count", fail_count_a, 0);
        chk("rst_failure", failure_a, 0);
        chk("rst_success", success_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_busy_b", busy_b, 0);
        rst_n = 1'b1;

        // first image traced byte by byte, then the full correct run
        pulse_start();
        chk("busy_after_start", busy_a, 1);
        run_image(0, 1'b1, 1'b0);
        @(negedge clk);
        chk("rv_one_cycle", result_valid_a, 0);
        chk("image_advanced", image_num_a, 1);
        for (int i = 1; i < 480; i++) run_image(i, 1'b1, 1'b0);
        @(negedge clk);
        chk("full_success", success_a, 1);
        chk("full_fail_count", fail_count_a, 0);
        chk("full_failure", failure_a, 0);
        chk("full_busy", busy_a, 0);
        chk("full_last_img", image_num_a, 479);
        chk("full_pulses", pulses_a, 480);

        // restart from DONE; step_en during FETCH and DRAIN must be dropped
        pulse_start();
        chk("restart_img", image_num_a, 0);
        chk("restart_success", success_a, 0);
        run_image(0, 1'b1, 1'b1);
        repeat (40) @(negedge clk);
        chk("spam_pulses", pulses_a, 481);
        chk("spam_img", image_num_a, 1);
        chk("spam_busy", busy_a, 1);

        // stop on first failure at image 7
        bad_a = 7;
        for (int i = 1; i < 8; i++) run_image(i, 1'b1, 1'b0);
        @(negedge clk);
        chk("stop_failure", failure_a, 1);
        chk("stop_fail_count", fail_count_a, 1);
        chk("stop_img", image_num_a, 7);
        chk("stop_busy", busy_a, 0);
        chk("stop_success", success_a, 0);
        step_a = 1'b1;
        @(negedge clk);
        step_a = 1'b0;
        repeat (40) @(negedge clk);
        chk("stop_rom_addr", rom_addr_a, 7 * 32 + 31);
        chk("stop_pulses", pulses_a, 488);

        // continue-on-fail instance, images 5 and 200 wrong
        sel = 1'b1;
        bad_b1 = 5;
        bad_b2 = 200;
        pulse_start();
        for (int i = 0; i < 480; i++) run_image(i, 1'b1, 1'b0);
        @(negedge clk);
        chk("cont_success", success_b, 0);
        chk("cont_fail_count", fail_count_b, 2);
        chk("cont_failure", failure_b, 1);
        chk("cont_last_img", image_num_b, 479);
        chk("cont_pulses", pulses_b, 480);

        // reset in the middle of image 3's fetch
        sel = 1'b0;
        bad_a = -1;
        pulse_start();
        for (int i = 0; i < 3; i++) run_image(i, 1'b0, 1'b0);
        cur_a = 3;
        @(negedge clk);
        step_a = 1'b1;
        @(negedge clk);
        step_a = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_core_data", core_data_a, 0);
        chk("mid_rst_rom_addr", rom_addr_a, 0);
        chk("mid_rst_busy", busy_a, 0);
        chk("mid_rst_img", image_num_a, 0);
        chk("mid_rst_index", result_index_a, 0);
        chk("mid_rst_label", expected_label_a, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid_rst_no_result", pulses_a, 491);

        // start and step together in IDLE: start wins
        start_a = 1'b1;
        step_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        step_a = 1'b0;
        repeat (40) @(negedge clk);
        chk("start_wins_busy", busy_a, 1);
        chk("start_wins_pulses", pulses_a, 491);
        run_image(0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
